// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/subtract unit: adds a WIDTH-bit operand pair CHUNK bits per clock through a
// CHUNK-wide full-adder ripple chain, carrying between chunks in a register.
module serial_chunk_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf
);

   localparam int unsigned N    = WIDTH / CHUNK;
   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             cy_q, cy_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic [CHUNK-1:0] x, y, s;
   logic             c_msb, c_out;

   always_comb begin
      x = '0;
      y = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (cnt_q == CntW'(k)) begin
            x = opa_q[k*CHUNK +: CHUNK];
            y = opb_q[k*CHUNK +: CHUNK];
         end
      end
   end

   // c_msb is the carry into the top cell; it only matters on the final chunk (overflow).
   always_comb begin : p_ripple
      logic c;
      s     = '0;
      c_msb = 1'b0;
      c     = cy_q;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         if (i == CHUNK - 1) begin
            c_msb = c;
         end
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      c_out = c;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cy_d    = cy_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               // Subtract as a + ~b + ~ci, so co reads as not-borrow.
               opa_d   = a;
               opb_d   = sub ? ~b : b;
               cy_d    = ci ^ sub;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            for (int unsigned k = 0; k < N; k++) begin
               if (cnt_q == CntW'(k)) begin
                  acc_d[k*CHUNK +: CHUNK] = s;
               end
            end
            cy_d = c_out;
            if (cnt_q == CntW'(N - 1)) begin
               state_d = StIdle;
               done_d  = 1'b1;
               sum_d   = acc_d;
               co_d    = c_out;
               ovf_d   = c_msb ^ c_out;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         cy_q    <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cy_q    <= cy_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == StRun);
   assign done = done_q;
   assign sum  = sum_q;
   assign co   = co_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: CHUNK = 1, 4 and 16 instances (WIDTH = 16) checked each cycle
// against an arithmetic model, plus directed literal expectations on the CHUNK = 4 instance.
module tb_serial_chunk_adder;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start_v [3];
   logic         sub_v   [3];
   logic         ci_v    [3];
   logic [W-1:0] a_v     [3];
   logic [W-1:0] b_v     [3];
   logic         busy_v  [3];
   logic         done_v  [3];
   logic         co_v    [3];
   logic         ovf_v   [3];
   logic [W-1:0] sum_v   [3];

   logic         m_busy [3];
   logic         m_done [3];
   logic         m_co   [3];
   logic         m_ovf  [3];
   logic [W-1:0] m_sum  [3];
   logic [17:0]  m_pend [3];
   int           m_rem  [3];

   int   checks   = 0;
   int   failures = 0;
   logic chk_en   = 1'b0;

   always #5 clk = ~clk;

   function automatic int chunk_of(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
   endfunction

   // Returns {ovf, co, sum} from plain integer arithmetic.
   function automatic logic [17:0] ref_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                                          input logic c);
      int   u, r;
      logic cy, ov;
      if (!s) begin
         u  = int'(a) + int'(b) + int'(c);
         cy = (u > 65535);
         r  = int'($signed(a)) + int'($signed(b)) + int'(c);
      end else begin
         u  = int'(a) - int'(b) - int'(c);
         cy = (u >= 0);
         r  = int'($signed(a)) - int'($signed(b)) - int'(c);
      end
      ov = (r > 32767) || (r < -32768);
      return {ov, cy, u[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_dut
      serial_chunk_adder #(
         .WIDTH(W),
         .CHUNK((g == 0) ? 1 : ((g == 1) ? 4 : 16))
      ) u_dut (
         .clk  (clk),
         .rst  (rst),
         .start(start_v[g]),
         .sub  (sub_v[g]),
         .a    (a_v[g]),
         .b    (b_v[g]),
         .ci   (ci_v[g]),
         .busy (busy_v[g]),
         .done (done_v[g]),
         .sum  (sum_v[g]),
         .co   (co_v[g]),
         .ovf  (ovf_v[g])
      );
   end

   // Model: an accepted request produces its result W/CHUNK edges later.
   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_rem[i]  <= 0;
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b0;
            m_sum[i]  <= '0;
            m_co[i]   <= 1'b0;
            m_ovf[i]  <= 1'b0;
            m_pend[i] <= '0;
         end else begin
            m_done[i] <= 1'b0;
            if (m_rem[i] > 0) begin
               m_rem[i] <= m_rem[i] - 1;
               if (m_rem[i] == 1) begin
                  m_sum[i]  <= m_pend[i][15:0];
                  m_co[i]   <= m_pend[i][16];
                  m_ovf[i]  <= m_pend[i][17];
                  m_done[i] <= 1'b1;
                  m_busy[i] <= 1'b0;
               end
            end else if (start_v[i]) begin
               m_pend[i] <= ref_op(sub_v[i], a_v[i], b_v[i], ci_v[i]);
               m_rem[i]  <= W / chunk_of(i);
               m_busy[i] <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(m_busy[i]));
            chk($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(m_done[i]));
            chk($sformatf("sum[%0d]", i), 32'(sum_v[i]), 32'(m_sum[i]));
            chk($sformatf("co[%0d]", i), 32'(co_v[i]), 32'(m_co[i]));
            chk($sformatf("ovf[%0d]", i), 32'(ovf_v[i]), 32'(m_ovf[i]));
         end
      end
   end

   // Call at #1 after a posedge; returns at #1 after the done edge.
   task automatic run_op(input int i, input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic c, output logic [15:0] rs, output logic rco,
                         output logic rov, output int lat, output int bcyc);
      start_v[i] = 1'b1;
      sub_v[i]   = s;
      a_v[i]     = a;
      b_v[i]     = b;
      ci_v[i]    = c;
      @(posedge clk);
      #1;
      start_v[i] = 1'b0;
      a_v[i]     = ~a;
      b_v[i]     = ~b;
      sub_v[i]   = ~s;
      ci_v[i]    = ~c;
      lat  = 0;
      bcyc = 0;
      while (!done_v[i] && lat < 200) begin
         if (busy_v[i]) bcyc++;
         @(posedge clk);
         #1;
         lat++;
      end
      if (!done_v[i]) chk($sformatf("done_timeout[%0d]", i), 32'(done_v[i]), 32'd1);
      rs  = sum_v[i];
      rco = co_v[i];
      rov = ovf_v[i];
   endtask

   task automatic dir_op(input string nm, input logic s, input logic [15:0] a,
                         input logic [15:0] b, input logic c, input logic [15:0] es,
                         input logic eco, input logic eov);
      logic [15:0] rs;
      logic        rco, rov;
      int          lat, bcyc;
      run_op(1, s, a, b, c, rs, rco, rov, lat, bcyc);
      chk({nm, "_sum"}, 32'(rs), 32'(es));
      chk({nm, "_co"}, 32'(rco), 32'(eco));
      chk({nm, "_ovf"}, 32'(rov), 32'(eov));
      chk({nm, "_lat"}, 32'(lat), 32'd4);
      chk({nm, "_busycyc"}, 32'(bcyc), 32'd4);
   endtask

   initial begin
      logic [15:0] rs, ra, rb;
      logic        rco, rov, rsub, rci;
      logic [17:0] e;
      int          lat, bcyc, n;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         sub_v[i]   = 1'b0;
         ci_v[i]    = 1'b0;
         a_v[i]     = '0;
         b_v[i]     = '0;
      end
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_busy", 32'(busy_v[1]), 32'd0);
      chk("rst_done", 32'(done_v[1]), 32'd0);
      chk("rst_sum", 32'(sum_v[1]), 32'd0);
      chk("rst_co", 32'(co_v[1]), 32'd0);
      chk("rst_ovf", 32'(ovf_v[1]), 32'd0);
      @(posedge clk);
      #1;

      // Back-to-back: each call starts in the previous done cycle.
      dir_op("add", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      dir_op("ripple", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      dir_op("posovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      dir_op("sub_borrow", 1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      dir_op("sub_ovf", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      dir_op("add_ci", 1'b0, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);

      // Start re-asserted with other operands while busy must be ignored.
      @(posedge clk);
      #1;
      start_v[1] = 1'b1;
      sub_v[1]   = 1'b0;
      ci_v[1]    = 1'b0;
      a_v[1]     = 16'h0100;
      b_v[1]     = 16'h0200;
      @(posedge clk);
      #1;
      start_v[1] = 1'b0;
      @(posedge clk);
      #1;
      start_v[1] = 1'b1;
      a_v[1]     = 16'hFFFF;
      b_v[1]     = 16'hFFFF;
      sub_v[1]   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      start_v[1] = 1'b0;
      n = 0;
      while (!done_v[1] && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("ignore_done", 32'(done_v[1]), 32'd1);
      chk("ignore_sum", 32'(sum_v[1]), 32'h0300);
      repeat (5) @(posedge clk);
      #1;
      chk("hold_sum", 32'(sum_v[1]), 32'h0300);
      chk("hold_busy", 32'(busy_v[1]), 32'd0);

      // Reset two cycles after accept.
      start_v[1] = 1'b1;
      sub_v[1]   = 1'b0;
      a_v[1]     = 16'h1111;
      b_v[1]     = 16'h2222;
      @(posedge clk);
      #1;
      start_v[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy_v[1]), 32'd0);
      chk("midrst_done", 32'(done_v[1]), 32'd0);
      chk("midrst_sum", 32'(sum_v[1]), 32'd0);
      chk("midrst_co", 32'(co_v[1]), 32'd0);
      chk("midrst_ovf", 32'(ovf_v[1]), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("postrst_done", 32'(done_v[1]), 32'd0);
      dir_op("postrst", 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 1000; k++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rsub = 1'($urandom);
            rci  = 1'($urandom);
            e    = ref_op(rsub, ra, rb, rci);
            run_op(i, rsub, ra, rb, rci, rs, rco, rov, lat, bcyc);
            chk($sformatf("sweep%0d_sum", chunk_of(i)), 32'(rs), 32'(e[15:0]));
            chk($sformatf("sweep%0d_co", chunk_of(i)), 32'(rco), 32'(e[16]));
            chk($sformatf("sweep%0d_ovf", chunk_of(i)), 32'(rov), 32'(e[17]));
            chk($sformatf("sweep%0d_lat", chunk_of(i)), 32'(lat), 32'(W / chunk_of(i)));
         end
      end

      repeat (2) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
